vga_rect_fill_arbiter: RTL and testbench

//  Hardware rectangle-fill engine plus write arbiter for the 100x100 VGA framebuffer write port.
//  The CPU configures a fill (corners + colour) and pulses start; the engine walks the rectangle
//  row-major, one pixel per cycle, replacing the software nested BLE/VGA loops.
//  The engine shares the single framebuffer write port with the CPU VGA-instruction path.
//  CPU single-pixel writes always win; the fill steps only in cycles with no CPU write.

---
 rtl/vga_rect_fill_arbiter_pkg.sv | 31 +++
 rtl/vga_rect_fill_arbiter_rect_cursor.sv | 48 ++++
 rtl/vga_rect_fill_arbiter.sv | 120 ++++++++++++
 tb/tb_vga_rect_fill_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rect_fill_arbiter_pkg.sv
// Shared constants, colour codes and FSM encoding for the rectangle-fill engine
// and its framebuffer write-port arbiter.
package vga_rect_fill_arbiter_pkg;

    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;
    localparam int FB_COLS = 100;
    localparam int FB_ROWS = 100;

    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(FB_COLS - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(FB_ROWS - 1);

    localparam logic [COLOR_W-1:0] COLOR_RED   = 3'b100;
    localparam logic [COLOR_W-1:0] COLOR_GREEN = 3'b010;
    localparam logic [COLOR_W-1:0] COLOR_BLUE  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // Saturate a coordinate to the last valid framebuffer index.
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] max_v
    );
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/vga_rect_fill_arbiter_rect_cursor.sv
// Row-major X/Y stepper over an already-clamped rectangle; flags the last pixel.
module rect_cursor
    import vga_rect_fill_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               last
);

    logic [COORD_W-1:0] x0_q;
    logic [COORD_W-1:0] x1_q;
    logic [COORD_W-1:0] y1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            cx   <= '0;
            cy   <= '0;
        end else if (load) begin
            x0_q <= x0;
            x1_q <= x1;
            y1_q <= y1;
            cx   <= x0;
            cy   <= y0;
        end else if (step) begin
            // Equality compares only: limits are pre-clamped so the cursor never wraps.
            if (cx != x1_q) begin
                cx <= cx + COORD_W'(1);
            end else if (cy != y1_q) begin
                cx <= x0_q;
                cy <= cy + COORD_W'(1);
            end
        end
    end

    assign last = (cx == x1_q) && (cy == y1_q);

endmodule

// File: rtl/vga_rect_fill_arbiter.sv
// Rectangle-fill engine sharing the framebuffer write port with CPU pixel writes;
// CPU writes always win and the fill cursor only advances in free cycles.
module vga_rect_fill_arbiter
    import vga_rect_fill_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_wr_en,
    input  logic [COORD_W-1:0] cpu_x,
    input  logic [COORD_W-1:0] cpu_y,
    input  logic [COLOR_W-1:0] cpu_color,
    input  logic               fill_start,
    input  logic [COORD_W-1:0] fill_x0,
    input  logic [COORD_W-1:0] fill_y0,
    input  logic [COORD_W-1:0] fill_x1,
    input  logic [COORD_W-1:0] fill_y1,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               fill_err,
    output logic               fb_wr_en,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [COLOR_W-1:0] fb_color,
    output logic [1:0]         state
);

    fill_state_t        state_q;
    logic [COLOR_W-1:0] color_q;
    logic [COORD_W-1:0] cx0, cy0, cx1, cy1;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic               cur_last;
    logic               fill_empty;
    logic               load;
    logic               step;

    assign cx0 = clamp_coord(fill_x0, MAX_X);
    assign cy0 = clamp_coord(fill_y0, MAX_Y);
    assign cx1 = clamp_coord(fill_x1, MAX_X);
    assign cy1 = clamp_coord(fill_y1, MAX_Y);

    assign fill_empty = (cx0 > cx1) || (cy0 > cy1);
    assign load       = (state_q == ST_IDLE) && fill_start;
    assign step       = (state_q == ST_FILL) && !cpu_wr_en;
    assign state      = state_q;

    rect_cursor u_cursor (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .x0   (cx0),
        .y0   (cy0),
        .x1   (cx1),
        .y1   (cy1),
        .cx   (cur_x),
        .cy   (cur_y),
        .last (cur_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            color_q   <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            fb_wr_en  <= 1'b0;
            fb_x      <= '0;
            fb_y      <= '0;
            fb_color  <= '0;
        end else begin
            fill_done <= 1'b0;

            // Fixed-priority write port: CPU, then fill cursor, else idle with held data.
            if (cpu_wr_en) begin
                fb_wr_en <= 1'b1;
                fb_x     <= cpu_x;
                fb_y     <= cpu_y;
                fb_color <= cpu_color;
            end else if (state_q == ST_FILL) begin
                fb_wr_en <= 1'b1;
                fb_x     <= cur_x;
                fb_y     <= cur_y;
                fb_color <= color_q;
            end else begin
                fb_wr_en <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (fill_start) begin
                        color_q  <= fill_color;
                        fill_err <= fill_empty;
                        if (fill_empty) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q   <= ST_FILL;
                            fill_busy <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (step && cur_last) begin
                        state_q   <= ST_DONE;
                        fill_busy <= 1'b0;
                    end
                end
                ST_DONE: begin
                    fill_done <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill_arbiter.sv
// Directed bench for the rectangle-fill arbiter: monitor logs every framebuffer
// write, done pulse and busy cycle; directed steps compare the logs to expectations.
module tb_vga_rect_fill_arbiter;
    import vga_rect_fill_arbiter_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_wr_en;
    logic [COORD_W-1:0] cpu_x, cpu_y;
    logic [COLOR_W-1:0] cpu_color;
    logic               fill_start;
    logic [COORD_W-1:0] fill_x0, fill_y0, fill_x1, fill_y1;
    logic [COLOR_W-1:0] fill_color;
    logic               fill_busy, fill_done, fill_err;
    logic               fb_wr_en;
    logic [COORD_W-1:0] fb_x, fb_y;
    logic [COLOR_W-1:0] fb_color;
    logic [1:0]         state;

    vga_rect_fill_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_x      (cpu_x),
        .cpu_y      (cpu_y),
        .cpu_color  (cpu_color),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_x1    (fill_x1),
        .fill_y1    (fill_y1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_err   (fill_err),
        .fb_wr_en   (fb_wr_en),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_color   (fb_color),
        .state      (state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge
    logic [18:0] wr_q[$];
    int          wr_cyc_q[$];
    int          done_q[$];
    int          busy_q[$];

    always @(negedge clk) begin
        if (fb_wr_en) begin
            wr_q.push_back({fb_x, fb_y, fb_color});
            wr_cyc_q.push_back(cyc);
        end
        if (fill_done) done_q.push_back(cyc);
        if (fill_busy) busy_q.push_back(cyc);
    end

    // Scoreboard state
    logic [18:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wb, db, bb, n;
    logic [63:0] cpu_mask;
    int          restart_at;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int at_or(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [18:0] cpu_pix(input int k);
        return {8'(40 + k), 8'(50 + k), COLOR_RED};
    endfunction

    // Expected write stream: fill pixels row-major, with CPU writes pre-empting
    // in the cycles flagged by cpu_mask (bit k = cycle n+k).
    task automatic build_exp(input int x0, input int y0, input int x1, input int y1,
                             input logic [2:0] col);
        logic [18:0] fq[$];
        int k;
        if (x0 > 99) x0 = 99;
        if (x1 > 99) x1 = 99;
        if (y0 > 99) y0 = 99;
        if (y1 > 99) y1 = 99;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                fq.push_back({8'(x), 8'(y), col});
        exp_q.delete();
        k = 1;
        while (fq.size() > 0) begin
            if (k < 64 && cpu_mask[k]) exp_q.push_back(cpu_pix(k));
            else exp_q.push_back(fq.pop_front());
            k++;
        end
    endtask

    // Driver: pulse start at cycle n, drive CPU strobes / a stray restart, run until done.
    task automatic do_fill(input int x0, input int y0, input int x1, input int y1,
                           input logic [2:0] col, input int budget);
        @(posedge clk); #1;
        wb = wr_q.size();
        db = done_q.size();
        bb = busy_q.size();
        n  = cyc;
        fill_x0    = 8'(x0);
        fill_y0    = 8'(y0);
        fill_x1    = 8'(x1);
        fill_y1    = 8'(y1);
        fill_color = col;
        fill_start = 1'b1;
        cpu_wr_en  = 1'b0;
        for (int k = 1; k < budget; k++) begin
            @(posedge clk); #1;
            fill_start = (k == restart_at);
            if (k == restart_at) begin
                fill_x0 = 8'd10; fill_y0 = 8'd10; fill_x1 = 8'd20; fill_y1 = 8'd20;
            end
            cpu_wr_en = (k < 64) && cpu_mask[k];
            cpu_x     = 8'(40 + k);
            cpu_y     = 8'(50 + k);
            cpu_color = COLOR_RED;
            if (done_q.size() > db) break;
        end
        cpu_wr_en  = 1'b0;
        fill_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cmp_seq(input string tag);
        int mism = 0;
        int got  = wr_q.size() - wb;
        chk({tag, "_count"}, got, exp_q.size());
        for (int i = 0; i < got && i < exp_q.size(); i++)
            if (wr_q[wb + i] !== exp_q[i]) mism++;
        chk({tag, "_seq"}, mism, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_wr_en = 1'b0; cpu_x = '0; cpu_y = '0; cpu_color = '0;
        fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_x1 = '0; fill_y1 = '0;
        fill_color = '0; cpu_mask = '0; restart_at = -1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_fb", int'({fb_wr_en, fb_x, fb_y, fb_color}), 0);
        chk("rst_flags", int'({fill_busy, fill_done, fill_err}), 0);
        chk("rst_state", int'(state), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: 4x4 green fill, no CPU traffic
        build_exp(0, 0, 3, 3, COLOR_GREEN);
        do_fill(0, 0, 3, 3, COLOR_GREEN, 200);
        cmp_seq("t1");
        chk("t1_first_cyc", at_or(wr_cyc_q, wb), n + 2);
        chk("t1_last_cyc", at_or(wr_cyc_q, wr_cyc_q.size() - 1), n + 17);
        chk("t1_done_cnt", done_q.size() - db, 1);
        chk("t1_done_cyc", at_or(done_q, db), n + 18);
        chk("t1_busy_first", at_or(busy_q, bb), n + 1);
        chk("t1_busy_last", at_or(busy_q, busy_q.size() - 1), n + 16);
        chk("t1_busy_cnt", busy_q.size() - bb, 16);
        chk("t1_err", int'(fill_err), 0);

        // 2: same fill, CPU steals cycles n+3, n+7, n+8
        cpu_mask = 64'h0;
        cpu_mask[3] = 1'b1; cpu_mask[7] = 1'b1; cpu_mask[8] = 1'b1;
        build_exp(0, 0, 3, 3, COLOR_GREEN);
        do_fill(0, 0, 3, 3, COLOR_GREEN, 200);
        cmp_seq("t2");
        chk("t2_total", wr_q.size() - wb, 19);
        chk("t2_cpu_a_cyc", at_or(wr_cyc_q, wb + 2), n + 4);
        chk("t2_last_cyc", at_or(wr_cyc_q, wr_cyc_q.size() - 1), n + 20);
        chk("t2_done_cyc", at_or(done_q, db), n + 21);
        cpu_mask = 64'h0;

        // 3: full screen blue
        build_exp(0, 0, 99, 99, COLOR_BLUE);
        do_fill(0, 0, 99, 99, COLOR_BLUE, 10100);
        cmp_seq("t3");
        chk("t3_last_pix", (wr_q.size() > wb) ? int'(wr_q[wr_q.size() - 1]) : -1,
            int'({8'd99, 8'd99, COLOR_BLUE}));
        chk("t3_done_cnt", done_q.size() - db, 1);
        chk("t3_done_cyc", at_or(done_q, db), n + 10002);

        // 4a: empty after clamp (X0 > X1)
        build_exp(5, 0, 4, 0, COLOR_RED);
        do_fill(5, 0, 4, 0, COLOR_RED, 50);
        chk("t4a_count", wr_q.size() - wb, 0);
        chk("t4a_err", int'(fill_err), 1);
        chk("t4a_done_cyc", at_or(done_q, db), n + 2);
        chk("t4a_busy_cnt", busy_q.size() - bb, 0);

        // 4b: X1=200 clamps to 99; accepted start clears the sticky error
        build_exp(90, 0, 200, 0, COLOR_RED);
        do_fill(90, 0, 200, 0, COLOR_RED, 50);
        cmp_seq("t4b");
        chk("t4b_err", int'(fill_err), 0);
        chk("t4b_last_pix", (wr_q.size() > wb) ? int'(wr_q[wr_q.size() - 1]) : -1,
            int'({8'd99, 8'd0, COLOR_RED}));
        chk("t4b_done_cyc", at_or(done_q, db), n + 12);

        // 5: second start mid-fill with other corners is ignored
        restart_at = 3;
        build_exp(2, 1, 4, 2, COLOR_RED);
        do_fill(2, 1, 4, 2, COLOR_RED, 50);
        cmp_seq("t5");
        chk("t5_done_cnt", done_q.size() - db, 1);
        restart_at = -1;

        // 6: reset after five fill writes aborts the fill
        @(posedge clk); #1;
        wb = wr_q.size(); db = done_q.size(); n = cyc;
        fill_x0 = 8'd0; fill_y0 = 8'd0; fill_x1 = 8'd3; fill_y1 = 8'd3;
        fill_color = COLOR_GREEN; fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
        for (int k = 0; k < 40 && (wr_q.size() - wb) < 5; k++) begin
            @(negedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_fb", int'({fb_wr_en, fb_x, fb_y, fb_color}), 0);
        chk("t6_flags", int'({fill_busy, fill_done, fill_err}), 0);
        chk("t6_state", int'(state), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_writes", wr_q.size() - wb, 5);
        chk("t6_no_done", done_q.size() - db, 0);
        build_exp(1, 1, 2, 2, COLOR_BLUE);
        do_fill(1, 1, 2, 2, COLOR_BLUE, 50);
        cmp_seq("t6_restart");
        chk("t6_restart_done", done_q.size() - db, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
